// File: rtl/pipes.sv
// Shared pipeline types for the five-stage core: PC and register index
// widths, the hazard scheduler state encoding and its stage control bundle.
package pipes;

  typedef logic [63:0] u64;
  typedef logic [4:0]  creg_addr_t;

  // RUN: normal issue, DWAIT: data bus transfer outstanding,
  // RWAIT: redirect parked until the in-flight fetch returns.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    RWAIT = 2'd2
  } hazard_state_t;

  // Per-stage hold and bubble controls driven by the hazard scheduler.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctl_t;

  // Whole pipe frozen behind the data bus; W gets a bubble because the
  // M-stage instruction has not completed.
  function automatic hazard_ctl_t ctlMemWait();
    hazard_ctl_t c;
    c         = '0;
    c.stall_f = 1'b1;
    c.stall_d = 1'b1;
    c.stall_e = 1'b1;
    c.stall_m = 1'b1;
    c.flush_w = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/loaduse_detect.sv
// Load-use comparator: flags a D-stage instruction that reads the
// destination of a load currently in E. Register 0 never creates a hazard.
module loaduse_detect
  import pipes::*;
(
  input  logic       ex_memread_i,
  input  creg_addr_t ex_dst_i,
  input  creg_addr_t id_ra1_i,
  input  creg_addr_t id_ra2_i,
  input  logic       id_use1_i,
  input  logic       id_use2_i,
  output logic       hazard_o
);

  logic hit1;
  logic hit2;

  assign hit1     = id_use1_i && (id_ra1_i == ex_dst_i);
  assign hit2     = id_use2_i && (id_ra2_i == ex_dst_i);
  assign hazard_o = ex_memread_i && (ex_dst_i != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall scheduler. Decides each cycle which stage
// registers hold, which take a bubble, and when a branch redirect may be
// released to fetch without colliding with an outstanding fetch.
// Optional feature: define HAZARD_PERF_EN to add three 32-bit wrapping
// performance counters (data-bus stall cycles, load-use cycles, redirects).
module hazard_ctrl
  import pipes::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ireq_valid,
  input  logic       iresp_data_ok,
  input  logic       dreq_valid,
  input  logic       dresp_data_ok,
  input  logic       ex_memread,
  input  creg_addr_t ex_dst,
  input  creg_addr_t id_ra1,
  input  creg_addr_t id_ra2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic       br_redirect,
  input  u64         br_target,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_w,
  output logic       pc_redirect,
  output u64         pc_target,
  output logic       drop_iresp
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_ldu_stall,
  output logic [31:0] perf_redirect
`endif
);

  hazard_state_t state_q, state_d;
  logic          pendValid_q, pendValid_d;
  u64            pendPc_q, pendPc_d;

  hazard_ctl_t   ctl;
  logic          memStall;
  logic          fetchBusy;
  logic          loadUse;
  logic          redirReq;
  u64            redirTarget;

  assign memStall  = dreq_valid && !dresp_data_ok;
  assign fetchBusy = ireq_valid && !iresp_data_ok;

  // A branch resolving this cycle is always the youngest one, so its target
  // supersedes anything parked. pend_valid is never set while in RUN, so in
  // RUN the request reduces to br_redirect alone.
  assign redirReq    = br_redirect || pendValid_q;
  assign redirTarget = br_redirect ? br_target : pendPc_q;

  loaduse_detect u_loaduse (
    .ex_memread_i (ex_memread),
    .ex_dst_i     (ex_dst),
    .id_ra1_i     (id_ra1),
    .id_ra2_i     (id_ra2),
    .id_use1_i    (id_use1),
    .id_use2_i    (id_use2),
    .hazard_o     (loadUse)
  );

  // State and parked-redirect registers; reset discards any pending redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pendValid_q <= 1'b0;
      pendPc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pendValid_q <= pendValid_d;
      pendPc_q    <= pendPc_d;
    end
  end

  // Next state and redirect parking; a DWAIT release cycle is handled like
  // a RUN cycle that may carry the parked redirect.
  always_comb begin
    state_d     = state_q;
    pendValid_d = pendValid_q;
    pendPc_d    = pendPc_q;
    case (state_q)
      RWAIT: begin
        if (memStall) begin
          state_d = DWAIT;
        end else if (iresp_data_ok) begin
          state_d     = RUN;
          pendValid_d = 1'b0;
        end
        if (br_redirect && !(iresp_data_ok && !memStall)) begin
          pendPc_d = br_target;
        end
      end
      default: begin
        if (memStall) begin
          state_d = DWAIT;
          if (br_redirect) begin
            pendValid_d = 1'b1;
            pendPc_d    = br_target;
          end
        end else if (redirReq && fetchBusy) begin
          state_d     = RWAIT;
          pendValid_d = 1'b1;
          pendPc_d    = redirTarget;
        end else begin
          state_d     = RUN;
          pendValid_d = 1'b0;
        end
      end
    endcase
  end

  // Stage controls and redirect strobe; everything is held at zero in reset.
  always_comb begin
    ctl         = '0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    drop_iresp  = 1'b0;
    if (!reset) begin
      case (state_q)
        RWAIT: begin
          if (memStall) begin
            ctl = ctlMemWait();
          end else begin
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
            if (iresp_data_ok) begin
              drop_iresp  = 1'b1;
              pc_redirect = 1'b1;
              pc_target   = redirTarget;
            end
          end
        end
        default: begin
          if (memStall) begin
            ctl = ctlMemWait();
          end else if (redirReq) begin
            ctl.flush_d = 1'b1;
            if (!fetchBusy) begin
              pc_redirect = 1'b1;
              pc_target   = redirTarget;
              drop_iresp  = iresp_data_ok;
            end
          end else if (loadUse) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
          end else if (fetchBusy) begin
            ctl.stall_f = 1'b1;
            ctl.flush_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_f = ctl.stall_f;
  assign stall_d = ctl.stall_d;
  assign stall_e = ctl.stall_e;
  assign stall_m = ctl.stall_m;
  assign flush_d = ctl.flush_d;
  assign flush_e = ctl.flush_e;
  assign flush_w = ctl.flush_w;

`ifdef HAZARD_PERF_EN
  logic [31:0] perfMem_q;
  logic [31:0] perfLdu_q;
  logic [31:0] perfRedir_q;

  // Event counters sample the decoded controls, so they only see events
  // that actually reached the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfMem_q   <= '0;
      perfLdu_q   <= '0;
      perfRedir_q <= '0;
    end else begin
      if (ctl.stall_m) perfMem_q   <= perfMem_q + 32'd1;
      if (ctl.flush_e) perfLdu_q   <= perfLdu_q + 32'd1;
      if (pc_redirect) perfRedir_q <= perfRedir_q + 32'd1;
    end
  end

  assign perf_mem_stall = perfMem_q;
  assign perf_ldu_stall = perfLdu_q;
  assign perf_redirect  = perfRedir_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: load-use, data-bus wait, parked and
// deferred redirects, target overwrite, and reset while a redirect waits.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic        iresp_data_ok;
  logic        dreq_valid;
  logic        dresp_data_ok;
  logic        ex_memread;
  logic [4:0]  ex_dst;
  logic [4:0]  id_ra1;
  logic [4:0]  id_ra2;
  logic        id_use1;
  logic        id_use2;
  logic        br_redirect;
  logic [63:0] br_target;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_w;
  logic        pc_redirect;
  logic [63:0] pc_target;
  logic        drop_iresp;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_mem_stall;
  logic [31:0] perf_ldu_stall;
  logic [31:0] perf_redirect;
`endif

  int checks = 0;
  int errors = 0;

  // Bit order: stall_f stall_d stall_e stall_m flush_d flush_e flush_w pc_redirect drop_iresp
  logic [8:0] ctlObs;
  assign ctlObs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                   flush_w, pc_redirect, drop_iresp};

  localparam logic [8:0] C_IDLE   = 9'b000000000;
  localparam logic [8:0] C_LDU    = 9'b110001000;
  localparam logic [8:0] C_FETCH  = 9'b100010000;
  localparam logic [8:0] C_MEM    = 9'b111100100;
  localparam logic [8:0] C_REDIR  = 9'b000010010;
  localparam logic [8:0] C_PARK   = 9'b000010000;
  localparam logic [8:0] C_RDROP  = 9'b000010011;
  localparam logic [8:0] C_RWDONE = 9'b100010011;

  hazard_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .iresp_data_ok (iresp_data_ok),
    .dreq_valid    (dreq_valid),
    .dresp_data_ok (dresp_data_ok),
    .ex_memread    (ex_memread),
    .ex_dst        (ex_dst),
    .id_ra1        (id_ra1),
    .id_ra2        (id_ra2),
    .id_use1       (id_use1),
    .id_use2       (id_use2),
    .br_redirect   (br_redirect),
    .br_target     (br_target),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .stall_e       (stall_e),
    .stall_m       (stall_m),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .flush_w       (flush_w),
    .pc_redirect   (pc_redirect),
    .pc_target     (pc_target),
    .drop_iresp    (drop_iresp)
`ifdef HAZARD_PERF_EN
    ,
    .perf_mem_stall (perf_mem_stall),
    .perf_ldu_stall (perf_ldu_stall),
    .perf_redirect  (perf_redirect)
`endif
  );

  // Free-running core clock, active edge on posedge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Lets the combinational outputs settle, then compares the control vector.
  task automatic checkCtl(input string tag, input logic [8:0] expected);
    #1;
    checkOutput(tag, {55'd0, ctlObs}, {55'd0, expected});
  endtask

  // Moves to the next falling edge and returns all inputs to idle.
  task automatic applyStimulus();
    @(negedge clk);
    ireq_valid    = 1'b0;
    iresp_data_ok = 1'b0;
    dreq_valid    = 1'b0;
    dresp_data_ok = 1'b0;
    ex_memread    = 1'b0;
    ex_dst        = 5'd0;
    id_ra1        = 5'd0;
    id_ra2        = 5'd0;
    id_use1       = 1'b0;
    id_use2       = 1'b0;
    br_redirect   = 1'b0;
    br_target     = 64'd0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus();
    // Busy inputs under reset must not leak to the outputs.
    dreq_valid  = 1'b1;
    ireq_valid  = 1'b1;
    br_redirect = 1'b1;
    br_target   = 64'h1234;
    ex_memread  = 1'b1; ex_dst = 5'd3; id_ra1 = 5'd3; id_use1 = 1'b1;
    checkCtl("reset_ctl", C_IDLE);
    checkOutput("reset_target", pc_target, 64'd0);

    applyStimulus();
    reset = 1'b0;
    checkCtl("idle_after_reset", C_IDLE);

    // Load-use on ra1, then the load moves on.
    applyStimulus();
    ex_memread = 1'b1; ex_dst = 5'd5; id_ra1 = 5'd5; id_use1 = 1'b1;
    checkCtl("ldu_ra1", C_LDU);
    applyStimulus();
    checkCtl("ldu_gone", C_IDLE);

    // Register 0 never stalls.
    applyStimulus();
    ex_memread = 1'b1; ex_dst = 5'd0; id_ra1 = 5'd0; id_use1 = 1'b1;
    checkCtl("ldu_x0", C_IDLE);

    // Load-use on ra2, and the same match without use2.
    applyStimulus();
    ex_memread = 1'b1; ex_dst = 5'd7; id_ra2 = 5'd7; id_use2 = 1'b1; id_ra1 = 5'd7;
    checkCtl("ldu_ra2", C_LDU);
    applyStimulus();
    ex_memread = 1'b1; ex_dst = 5'd7; id_ra2 = 5'd7; id_ra1 = 5'd7;
    checkCtl("ldu_unused_src", C_IDLE);

    // Load-use beats the fetch stall; then a plain fetch stall.
    applyStimulus();
    ireq_valid = 1'b1;
    ex_memread = 1'b1; ex_dst = 5'd9; id_ra1 = 5'd9; id_use1 = 1'b1;
    checkCtl("ldu_over_fetch", C_LDU);
    applyStimulus();
    ireq_valid = 1'b1;
    checkCtl("fetch_stall", C_FETCH);

    // Data wait for three cycles, response on the fourth.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      dreq_valid = 1'b1;
      checkCtl($sformatf("dwait_%0d", i), C_MEM);
    end
    applyStimulus();
    dreq_valid = 1'b1; dresp_data_ok = 1'b1;
    checkCtl("dwait_release", C_IDLE);
    applyStimulus();
    checkCtl("dwait_after", C_IDLE);

    // Redirect captured during DWAIT, applied in the release cycle.
    applyStimulus();
    dreq_valid = 1'b1; br_redirect = 1'b1; br_target = 64'h8000_0040;
    checkCtl("dw_redir_c1", C_MEM);
    applyStimulus();
    dreq_valid = 1'b1;
    checkCtl("dw_redir_c2", C_MEM);
    applyStimulus();
    dreq_valid = 1'b1; dresp_data_ok = 1'b1;
    checkCtl("dw_redir_release", C_REDIR);
    checkOutput("dw_redir_target", pc_target, 64'h8000_0040);
    applyStimulus();
    checkCtl("dw_redir_once", C_IDLE);

    // Redirect with a fetch outstanding: park, wait, release on response.
    applyStimulus();
    br_redirect = 1'b1; br_target = 64'h1000_0200; ireq_valid = 1'b1;
    checkCtl("rw_park", C_PARK);
    applyStimulus();
    ireq_valid = 1'b1;
    checkCtl("rw_wait", C_FETCH);
    applyStimulus();
    ireq_valid = 1'b1; iresp_data_ok = 1'b1;
    checkCtl("rw_release", C_RWDONE);
    checkOutput("rw_target", pc_target, 64'h1000_0200);
    applyStimulus();
    checkCtl("rw_back_run", C_IDLE);

    // A newer branch while parked replaces the target.
    applyStimulus();
    br_redirect = 1'b1; br_target = 64'hAAAA_0000; ireq_valid = 1'b1;
    checkCtl("ow_park", C_PARK);
    applyStimulus();
    br_redirect = 1'b1; br_target = 64'hBBBB_0010; ireq_valid = 1'b1;
    checkCtl("ow_new_branch", C_FETCH);
    applyStimulus();
    ireq_valid = 1'b1; iresp_data_ok = 1'b1;
    checkCtl("ow_release", C_RWDONE);
    checkOutput("ow_target", pc_target, 64'hBBBB_0010);

    // Redirect in RUN coinciding with an arriving response drops it.
    applyStimulus();
    br_redirect = 1'b1; br_target = 64'h0000_0F00; ireq_valid = 1'b1; iresp_data_ok = 1'b1;
    checkCtl("run_redir_drop", C_RDROP);
    checkOutput("run_redir_target", pc_target, 64'h0000_0F00);
    applyStimulus();
    checkCtl("run_redir_once", C_IDLE);

`ifdef HAZARD_PERF_EN
    checkOutput("perf_ldu", {32'd0, perf_ldu_stall}, 64'd3);
    checkOutput("perf_mem", {32'd0, perf_mem_stall}, 64'd5);
    checkOutput("perf_redirect", {32'd0, perf_redirect}, 64'd4);
`endif

    // Reset while a redirect is parked in RWAIT loses the redirect.
    applyStimulus();
    br_redirect = 1'b1; br_target = 64'hDEAD_0000; ireq_valid = 1'b1;
    checkCtl("rst_park", C_PARK);
    applyStimulus();
    ireq_valid = 1'b1;
    checkCtl("rst_rwait", C_FETCH);
    applyStimulus();
    reset = 1'b1; ireq_valid = 1'b1; iresp_data_ok = 1'b1;
    checkCtl("rst_forced", C_IDLE);
    checkOutput("rst_forced_target", pc_target, 64'd0);
    applyStimulus();
    reset = 1'b0; ireq_valid = 1'b1;
    checkCtl("rst_plain_fetch", C_FETCH);
    applyStimulus();
    ireq_valid = 1'b1; iresp_data_ok = 1'b1;
    checkCtl("rst_no_redirect", C_IDLE);
`ifdef HAZARD_PERF_EN
    checkOutput("perf_after_reset", {32'd0, perf_redirect}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
